// File: rtl/router_fifo_ctrl.sv
// Port-buffer controller for one router port: writes words into an external dual-port RAM,
// prefetches them, and serves them from a 2-entry output buffer.
module router_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH+1:0] level_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_wr_o,
    output logic [DATA_WIDTH-1:0] ram_data_in_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd_o,
    input  logic [DATA_WIDTH-1:0] ram_data_out_i
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PtrOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count, ram_count_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_count_q, ob_count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ADDR_WIDTH+1:0] level_q, level_d;
    logic                  push, pop, issue;
    logic [2:0]            ob_occ;

    assign ram_count   = wr_ptr_q - rd_ptr_q;
    assign in_ready_o  = (ram_count != DepthCnt);
    assign out_valid_o = (ob_count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Buffer slots already claimed once this cycle's pop is accounted for.
    assign ob_occ = 3'(ob_count_q) + 3'(inflight_q) - 3'(pop);
    assign issue  = (ram_count != '0) && (ob_occ < 3'd2);

    assign ram_wr_en_o   = push;
    assign ram_data_in_o = in_data_i;
    assign ram_addr_wr_o = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_addr_rd_o = issue ? rd_ptr_q[ADDR_WIDTH-1:0] : raddr_q;
    assign out_data_o    = head_q;
    assign level_o       = level_q;

    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + PtrOne : rd_ptr_q;
        raddr_d    = ram_addr_rd_o;
        inflight_d = issue;
        ob_count_d = ob_count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        case ({inflight_q, pop})
            2'b01: begin
                head_d     = tail_q;
                ob_count_d = ob_count_q - 2'd1;
            end
            2'b10: begin
                if (ob_count_q == 2'd0) begin
                    head_d = ram_data_out_i;
                end else begin
                    tail_d = ram_data_out_i;
                end
                ob_count_d = ob_count_q + 2'd1;
            end
            2'b11: begin
                if (ob_count_q == 2'd1) begin
                    head_d = ram_data_out_i;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_data_out_i;
                end
            end
            default: ;
        endcase

        // Flush also drops the word returning next cycle by clearing inflight.
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            raddr_d    = '0;
            inflight_d = 1'b0;
            ob_count_d = 2'd0;
            head_d     = '0;
            tail_d     = '0;
        end

        ram_count_d = wr_ptr_d - rd_ptr_d;
        level_d     = (ADDR_WIDTH+2)'(ram_count_d) + (ADDR_WIDTH+2)'(inflight_d)
                    + (ADDR_WIDTH+2)'(ob_count_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            ob_count_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            raddr_q    <= raddr_d;
            inflight_q <= inflight_d;
            ob_count_q <= ob_count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
        end
    end

endmodule

// File: tb/tb_router_fifo_ctrl.sv
// Bench for router_fifo_ctrl: behavioural RAM plus a word-queue reference model.
module tb_router_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned Depth = 16;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, ram_wr_en;
    logic [DW-1:0] in_data, out_data, ram_data_in, ram_data_out;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_addr_wr, ram_addr_rd;

    logic [DW-1:0] mem [Depth];
    logic [DW-1:0] q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            accepted;

    always #5 clk = ~clk;

    // Dual-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr_wr] <= ram_data_in;
        ram_data_out <= mem[ram_addr_rd];
    end

    router_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .level_o        (level),
        .ram_wr_en_o    (ram_wr_en),
        .ram_addr_wr_o  (ram_addr_wr),
        .ram_data_in_o  (ram_data_in),
        .ram_addr_rd_o  (ram_addr_rd),
        .ram_data_out_i (ram_data_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic          stalled;
        logic [DW-1:0] held;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_eq("wr_en", 32'(ram_wr_en), 32'(iv & in_ready));
        stalled = out_valid & !ordy & !fl;
        held    = out_data;
        if (fl) begin
            q.delete();
        end else begin
            if (out_valid && ordy) begin
                check_eq("pop_has_word", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    check_eq("pop_data", 32'(out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (iv && in_ready) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("level", 32'(level), 32'(q.size()));
        if (out_valid) check_eq("ov_has_word", 32'(q.size() != 0), 32'd1);
        if (q.size() < Depth) check_eq("in_ready_room", 32'(in_ready), 32'd1);
        if (stalled) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", 32'(out_data), 32'(held));
        end
    endtask

    task automatic build_level5();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("pre_level5", 32'(level), 32'd5);
    endtask

    task automatic push_3c_and_drain(input string tag);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq({tag, "_first_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_first_data"}, 32'(out_data), 32'h3C);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);

        // Latency: push at E0, visible after E0+2.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("lat_e0_valid", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("lat_e1_valid", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("lat_e2_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check_eq("lat_hold_data", 32'(out_data), 32'hA5);
            check_eq("lat_hold_level", 32'(level), 32'd1);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming: 64 words through a 16-deep RAM, one per cycle.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (i >= 2) check_eq("stream_tput", 32'(out_valid), 32'd1);
        end
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("stream_empty", 32'(level), 32'd0);

        // Full and backpressure.
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) accepted++;
            step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        end
        check_eq("full_accepted", 32'(accepted), 32'd18);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_level", 32'(level), 32'd18);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("full_in_ready_rise", 32'(in_ready), 32'd1);
        repeat (24) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("full_drained", 32'(level), 32'd0);

        // Random handshakes.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (30) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("rand_drained", 32'(level), 32'd0);

        // Flush with a read in flight.
        build_level5();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("flush_level", 32'(level), 32'd0);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("flush_discard", 32'(out_valid), 32'd0);
        push_3c_and_drain("flush");

        // Asynchronous reset with a read in flight.
        build_level5();
        rst_n = 1'b0;
        #1;
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("arst_discard", 32'(out_valid), 32'd0);
        push_3c_and_drain("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo_ctrl.md
Name: router_fifo_ctrl

Overview:
- Control and output stage for one router port buffer, directly upstream and downstream of the shared dual-port RAM (registered read, 1-cycle read latency, write-enable, separate read/write addresses).
- Accepts words on a valid/ready write interface and generates RAM write strobes and addresses.
- Issues RAM reads ahead of demand and holds returned words in a 2-entry output buffer. This gives a valid/ready read interface with full throughput under backpressure.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
ADDR_WIDTH, 8, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all contents
in_valid  input  1  write data valid
in_ready  output  1  controller can accept a write
in_data  input  DATA_WIDTH  write data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data
out_data  output  DATA_WIDTH  head word (registered)
level  output  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer)
ram_wr_en  output  1  to RAM wr_en
ram_addr_wr  output  ADDR_WIDTH  to RAM addr_wr
ram_data_in  output  DATA_WIDTH  to RAM data_in
ram_addr_rd  output  ADDR_WIDTH  to RAM addr_rd
ram_data_out  input  DATA_WIDTH  from RAM data_out

Behaviour:
- Reset (rst_n low, asynchronous): all pointers and counts are 0, inflight is 0, output buffer is empty, out_valid is 0, out_data is 0, level is 0, in_ready is 1.
- Reset takes effect mid-transfer with no completion of pending reads; words already in the RAM are discarded.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits drive ram_addr_wr and ram_addr_rd; the pointers wrap naturally.
  - ram_count = wr_ptr - rd_ptr, in the range 0..DEPTH.
- Write:
  - in_ready = (ram_count != DEPTH).
  - push = in_valid & in_ready.
  - ram_wr_en = push (combinational); ram_data_in = in_data; wr_ptr increments on a push edge.
- Read issue:
  - pop = out_valid & out_ready.
  - issue = (ram_count != 0) & (ob_count + inflight - pop < 2).
  - On issue, ram_addr_rd = rd_ptr[ADDR_WIDTH-1:0] and rd_ptr increments at the edge.
  - ram_addr_rd holds its last value when there is no issue.
  - inflight <= issue on every edge.
- Read return: in the cycle with inflight = 1, ram_data_out is the requested word and is written into the output buffer at the next edge.
- Output buffer: 2-entry register FIFO (head/tail).
  - out_data is the head register; out_valid = (ob_count != 0).
  - A simultaneous load and pop is allowed.
  - out_data stays stable while out_valid & !out_ready.
- A word pushed at edge E is readable from the RAM from cycle E+1 (no read-during-write hazard).
- Latency: with the controller empty, a push at edge E0 gives out_valid = 1 after edge E0+2.
- Throughput: 1 word/cycle sustained with out_ready held at 1.
- Level:
  - level = ram_count + inflight + ob_count, registered and updated every edge.
  - Maximum value is DEPTH+2.
- Simultaneous push and issue with ram_count = 0: no issue that cycle; the issue occurs in the following cycle.
- Full: with ram_count = DEPTH, in_ready = 0; a pop frees RAM space only once the next issue increments rd_ptr.
- Flush (synchronous, highest priority over push/issue/pop):
  - Next state equals the reset state, except ram_addr_rd/ram_addr_wr simply follow the cleared pointers.
  - RAM contents are not cleared.
  - Data returned in the cycle after a flush edge is discarded: inflight is forced to 0.

Test Plan:
- Reset/idle: rst_n low for 3 cycles, then high, no stimulus -> out_valid = 0, in_ready = 1, level = 0, ram_wr_en = 0.
- Latency: push 0xA5 at edge E0 with out_ready = 0 -> out_valid = 1 and out_data = 0xA5 after E0+2; out_data holds 0xA5 for 10 cycles; level = 1.
- Streaming: ADDR_WIDTH = 4, push 0x00..0x3F continuously with out_ready = 1 -> output in order, 1 word/cycle after the initial 2-cycle latency, pointers wrap 4 times, no drop or duplicate.
- Full/backpressure: ADDR_WIDTH = 4, out_ready = 0, push 20 words:
  - the first 18 are accepted (16 RAM + 2 output buffer);
  - in_ready = 0 and level = 18 thereafter.
  - Then out_ready = 1 -> the 18 words drain in order; in_ready rises one cycle after the first issue.
- Random handshakes: 2000 cycles with random in_valid/out_ready at 50% -> scoreboard match, level always equals pushes - pops.
- Flush/reset mid-transfer: flush, or rst_n low, asserted with level = 5 and one read in flight -> the next cycle has level = 0 and out_valid = 0; a subsequent push of 0x3C is the first word output.
